// File: rtl/reg_file_mp.sv
// Multi-ported register file: two write ports (port 1 wins), NUM_RD
// combinational read ports with optional same-cycle forwarding, and a
// per-register pending scoreboard with a running population count.
module reg_file_mp #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 32,
   parameter int unsigned NUM_RD     = 2,
   parameter int unsigned BYPASS     = 1,
   localparam int unsigned AW        = $clog2(NUM_REGS),
   localparam int unsigned CW        = $clog2(NUM_REGS + 1)
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_we0,
   input  logic [AW-1:0]                i_waddr0,
   input  logic [DATA_WIDTH-1:0]        i_wdata0,
   input  logic                         i_we1,
   input  logic [AW-1:0]                i_waddr1,
   input  logic [DATA_WIDTH-1:0]        i_wdata1,
   input  logic [NUM_RD*AW-1:0]         i_raddr,
   output logic [NUM_RD*DATA_WIDTH-1:0] o_rdata,
   input  logic                         i_alloc_en,
   input  logic [AW-1:0]                i_alloc_addr,
   output logic [NUM_REGS-1:0]          o_pending,
   output logic [NUM_RD-1:0]            o_rbusy,
   output logic [CW-1:0]                o_pend_cnt,
   output logic                         o_wr_collide
);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]   pending_q, pending_d;
   logic [CW-1:0]         pend_cnt_q, pend_cnt_d;
   logic                  wr_collide_q, wr_collide_d;

   logic wv0, wv1, av;
   logic inc, dec0, dec1;

   // Effective (non-zero address) write and allocate qualifiers
   assign wv0 = i_we0 && (i_waddr0 != '0);
   assign wv1 = i_we1 && (i_waddr1 != '0);
   assign av  = i_alloc_en && (i_alloc_addr != '0);

   // Next register contents; port 1 applied last so it wins on a collision
   always_comb begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_d[i] = regs_q[i];
      if (wv0) regs_d[i_waddr0] = i_wdata0;
      if (wv1) regs_d[i_waddr1] = i_wdata1;
      regs_d[0] = '0;
   end

   // Scoreboard next state: writes clear, allocate sets and wins; count tracks edges
   always_comb begin
      pending_d = pending_q;
      if (wv0) pending_d[i_waddr0] = 1'b0;
      if (wv1) pending_d[i_waddr1] = 1'b0;
      if (av)  pending_d[i_alloc_addr] = 1'b1;
      pending_d[0] = 1'b0;

      inc  = av && !pending_q[i_alloc_addr];
      dec0 = wv0 && pending_q[i_waddr0] && !(av && (i_alloc_addr == i_waddr0));
      dec1 = wv1 && pending_q[i_waddr1] && !(av && (i_alloc_addr == i_waddr1))
             && !(wv0 && (i_waddr0 == i_waddr1));
      pend_cnt_d = pend_cnt_q + CW'(inc) - CW'(dec0) - CW'(dec1);

      wr_collide_d = wv0 && wv1 && (i_waddr0 == i_waddr1);
   end

   // State registers with asynchronous active-high reset
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
         pending_q    <= '0;
         pend_cnt_q   <= '0;
         wr_collide_q <= 1'b0;
      end else begin
         for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= regs_d[i];
         pending_q    <= pending_d;
         pend_cnt_q   <= pend_cnt_d;
         wr_collide_q <= wr_collide_d;
      end
   end

   assign o_pending    = pending_q;
   assign o_pend_cnt   = pend_cnt_q;
   assign o_wr_collide = wr_collide_q;

   for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
      logic [AW-1:0]         ra;
      logic [DATA_WIDTH-1:0] rd;
      logic                  hit0, hit1, busy;

      assign ra   = i_raddr[k*AW +: AW];
      assign hit0 = wv0 && (i_waddr0 == ra);
      assign hit1 = wv1 && (i_waddr1 == ra);

      // Read mux with optional forwarding; address 0 never hits a write
      always_comb begin
         rd   = regs_q[ra];
         busy = pending_q[ra];
         if (BYPASS != 0) begin
            if (hit1)      rd = i_wdata1;
            else if (hit0) rd = i_wdata0;
            if (hit0 || hit1) busy = 1'b0;
         end
      end

      assign o_rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd;
      assign o_rbusy[k] = busy;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one forwarding instance and one
// non-forwarding instance share the same stimulus.
module tb_reg_file_mp;

   localparam int unsigned DW = 32;
   localparam int unsigned NR = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned CW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          we0, we1, alloc_en;
   logic [AW-1:0] waddr0, waddr1, alloc_addr;
   logic [DW-1:0] wdata0, wdata1;
   logic [2*AW-1:0] raddr;

   logic [2*DW-1:0] rdata_b, rdata_n;
   logic [NR-1:0]   pend_b, pend_n;
   logic [1:0]      rbusy_b, rbusy_n;
   logic [CW-1:0]   cnt_b, cnt_n;
   logic            coll_b, coll_n;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   reg_file_mp #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(2), .BYPASS(1)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_we0(we0), .i_waddr0(waddr0), .i_wdata0(wdata0),
      .i_we1(we1), .i_waddr1(waddr1), .i_wdata1(wdata1),
      .i_raddr(raddr), .o_rdata(rdata_b),
      .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr),
      .o_pending(pend_b), .o_rbusy(rbusy_b), .o_pend_cnt(cnt_b),
      .o_wr_collide(coll_b)
   );

   reg_file_mp #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(2), .BYPASS(0)) dut_nb (
      .i_clk(clk), .i_rst(rst),
      .i_we0(we0), .i_waddr0(waddr0), .i_wdata0(wdata0),
      .i_we1(we1), .i_waddr1(waddr1), .i_wdata1(wdata1),
      .i_raddr(raddr), .o_rdata(rdata_n),
      .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr),
      .o_pending(pend_n), .o_rbusy(rbusy_n), .o_pend_cnt(cnt_n),
      .o_wr_collide(coll_n)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      we0 = 1'b0; we1 = 1'b0; alloc_en = 1'b0;
      waddr0 = '0; waddr1 = '0; alloc_addr = '0;
      wdata0 = '0; wdata1 = '0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      raddr = '0;

      // Reset state
      @(negedge clk);
      chk("rst_pend", 64'(pend_b), 64'h0);
      chk("rst_cnt", 64'(cnt_b), 64'h0);
      chk("rst_coll", 64'(coll_b), 64'h0);
      chk("rst_rdata", 64'(rdata_b), 64'h0);
      @(negedge clk);
      rst = 1'b0;

      // Write x5 then read on both ports; x0 reads zero
      @(negedge clk);
      we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
      @(negedge clk);
      idle();
      raddr = {5'd5, 5'd5};
      #1;
      chk("x5_both_b", 64'(rdata_b), 64'hDEADBEEF_DEADBEEF);
      chk("x5_both_n", 64'(rdata_n), 64'hDEADBEEF_DEADBEEF);
      raddr = {5'd5, 5'd0};
      #1;
      chk("x0_read", 64'(rdata_b), 64'hDEADBEEF_00000000);

      // Same-address collision, port 1 wins
      @(negedge clk);
      we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
      we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
      @(negedge clk);
      idle();
      raddr = {5'd0, 5'd7};
      #1;
      chk("coll_pulse", 64'(coll_b), 64'h1);
      chk("coll_data", 64'(rdata_n[31:0]), 64'h22);
      @(negedge clk);
      chk("coll_clear", 64'(coll_b), 64'h0);

      // Forwarding vs stored value on same-cycle write
      @(negedge clk);
      we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h1234;
      @(negedge clk);
      wdata0 = 32'hA5A5;
      raddr = {5'd0, 5'd3};
      #1;
      chk("byp_b", 64'(rdata_b[31:0]), 64'hA5A5);
      chk("byp_n_old", 64'(rdata_n[31:0]), 64'h1234);
      @(negedge clk);
      idle();
      #1;
      chk("byp_n_new", 64'(rdata_n[31:0]), 64'hA5A5);

      // Forwarding priority: port 1 over port 0
      @(negedge clk);
      we0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'hAA;
      we1 = 1'b1; waddr1 = 5'd8; wdata1 = 32'hBB;
      raddr = {5'd8, 5'd0};
      #1;
      chk("byp_prio", 64'(rdata_b[63:32]), 64'hBB);
      @(negedge clk);
      idle();

      // Scoreboard: allocate x4, x9, x4 then dual clear
      alloc_en = 1'b1; alloc_addr = 5'd4;
      @(negedge clk);
      alloc_addr = 5'd9;
      @(negedge clk);
      alloc_addr = 5'd4;
      @(negedge clk);
      idle();
      raddr = {5'd0, 5'd4};
      #1;
      chk("sb_cnt2", 64'(cnt_b), 64'h2);
      chk("sb_pend", 64'(pend_b), 64'h0000_0210);
      chk("sb_rbusy", 64'(rbusy_b), 64'h1);
      we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h44;
      we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99;
      @(negedge clk);
      idle();
      raddr = {5'd9, 5'd4};
      #1;
      chk("sb_pend0", 64'(pend_b), 64'h0);
      chk("sb_cnt0", 64'(cnt_b), 64'h0);
      chk("sb_cnt0_n", 64'(cnt_n), 64'h0);
      chk("dual_wr", 64'(rdata_b), 64'h00000099_00000044);

      // Allocate wins over same-cycle write; forwarding masks rbusy
      @(negedge clk);
      alloc_en = 1'b1; alloc_addr = 5'd6;
      @(negedge clk);
      idle();
      raddr = {5'd0, 5'd6};
      #1;
      chk("busy_x6", 64'(rbusy_b), 64'h1);
      we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h66;
      alloc_en = 1'b1; alloc_addr = 5'd6;
      #1;
      chk("busy_byp_b", 64'(rbusy_b), 64'h0);
      chk("busy_byp_n", 64'(rbusy_n), 64'h1);
      @(negedge clk);
      idle();
      #1;
      chk("alloc_wins", 64'(pend_b), 64'h0000_0040);
      chk("alloc_wins_cnt", 64'(cnt_b), 64'h1);
      chk("x6_data", 64'(rdata_b[31:0]), 64'h66);

      // Writes and allocates to x0 are ignored
      @(negedge clk);
      we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
      we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'h1;
      alloc_en = 1'b1; alloc_addr = 5'd0;
      raddr = {5'd0, 5'd0};
      #1;
      chk("x0_nobyp", 64'(rdata_b), 64'h0);
      @(negedge clk);
      idle();
      #1;
      chk("x0_pend", 64'(pend_b), 64'h0000_0040);
      chk("x0_coll", 64'(coll_b), 64'h0);
      chk("x0_data", 64'(rdata_n), 64'h0);

      // Fill x1..x31, then three pending bits
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         we0 = 1'b1; waddr0 = 5'(i); wdata0 = 32'h1000_0000 + 32'(i);
      end
      @(negedge clk);
      idle();
      alloc_en = 1'b1; alloc_addr = 5'd10;
      @(negedge clk);
      alloc_addr = 5'd11;
      @(negedge clk);
      alloc_addr = 5'd12;
      @(negedge clk);
      idle();
      raddr = {5'd31, 5'd1};
      #1;
      chk("fill_data", 64'(rdata_n), 64'h1000001F_10000001);
      chk("fill_cnt", 64'(cnt_b), 64'h3);
      chk("fill_pend", 64'(pend_b), 64'h0000_1C00);

      // Mid-cycle reset: everything clears before the edge; reset-cycle write lost
      @(negedge clk);
      we0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'hBAD;
      raddr = {5'd20, 5'd31};
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_pend", 64'(pend_b), 64'h0);
      chk("mid_rst_cnt", 64'(cnt_b), 64'h0);
      chk("mid_rst_busy", 64'(rbusy_b), 64'h0);
      chk("mid_rst_rd_b", 64'(rdata_b), 64'h00000BAD_00000000);
      chk("mid_rst_rd_n", 64'(rdata_n), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      #1;
      chk("post_rst_rd", 64'(rdata_b), 64'h0);
      chk("post_rst_coll", 64'(coll_b), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
